// File: rtl/cheshire_board_ctrl_if.sv
// Fan duty write bus between software-facing logic and the board controller.
// The driver owns the duty value and its write strobe.
interface cheshire_board_ctrl_if #(
    parameter int PwmWidth = 8
);
    logic [PwmWidth-1:0] fan_duty_i;
    logic                fan_duty_we_i;

    modport master (output fan_duty_i, output fan_duty_we_i);
    modport slave  (input  fan_duty_i, input  fan_duty_we_i);
endinterface

// File: rtl/cheshire_board_ctrl.sv
// Board control: input sync/debounce, SoC reset sequencing with boot-mode
// latch, and a fan PWM whose duty changes only at period boundaries.
module cheshire_board_ctrl #(
    parameter int          NumButtons      = 4,
    parameter int          DebounceCycles  = 1000,
    parameter int          ResetHoldCycles = 1024,
    parameter int          BootModeWidth   = 2,
    parameter int          PwmWidth        = 8,
    parameter int unsigned FanDutyDefault  = 32'hFF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cpu_reset_i,
    input  logic [NumButtons-1:0]    btn_i,
    input  logic [BootModeWidth-1:0] boot_mode_i,
    cheshire_board_ctrl_if.slave     duty_bus,
    output logic                     soc_rst_no,
    output logic [BootModeWidth-1:0] boot_mode_o,
    output logic [NumButtons-1:0]    btn_o,
    output logic [NumButtons-1:0]    btn_pulse_o,
    output logic                     fan_pwm_o,
    output logic                     fan_sw_o
);
    localparam int NumDb = NumButtons + 1;
    localparam int DbW   = $clog2(DebounceCycles + 1);
    localparam int HoldW = $clog2(ResetHoldCycles);

    localparam logic [DbW-1:0]      DbLast   = DbW'(DebounceCycles - 1);
    localparam logic [HoldW-1:0]    HoldLast = HoldW'(ResetHoldCycles - 1);
    localparam logic [PwmWidth-1:0] CntLast  = PwmWidth'((1 << PwmWidth) - 2);
    localparam logic [PwmWidth-1:0] DutyRst  = PwmWidth'(FanDutyDefault);

    typedef enum logic {HOLD, RUN} state_e;

    // Bit 0 carries the reset button, upper bits the user buttons.
    logic [NumDb-1:0]         sync1_q, sync2_q;
    logic [BootModeWidth-1:0] boot_s1_q, boot_s2_q;
    logic [NumDb-1:0]         lvl_q, lvl_d;
    logic [DbW-1:0]           db_cnt_q [NumDb];
    logic [DbW-1:0]           db_cnt_d [NumDb];
    logic [NumButtons-1:0]    pulse_q, pulse_d;
    logic                     rst_rise;

    state_e                   state_q, state_d;
    logic [HoldW-1:0]         hold_q, hold_d;
    logic                     soc_rst_q, soc_rst_d;
    logic [BootModeWidth-1:0] boot_q, boot_d;

    logic [PwmWidth-1:0]      pcnt_q, pcnt_d;
    logic [PwmWidth-1:0]      pend_q, pend_d;
    logic [PwmWidth-1:0]      act_q, act_d;
    logic                     pwm_q, pwm_d;
    logic                     sw_q, sw_d;
    logic                     wrap;

    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < NumDb; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                lvl_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        pulse_d  = lvl_d[NumDb-1:1] & ~lvl_q[NumDb-1:1];
        rst_rise = lvl_d[0] & ~lvl_q[0];
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        soc_rst_d = soc_rst_q;
        boot_d    = boot_q;
        unique case (state_q)
            HOLD: begin
                soc_rst_d = 1'b0;
                if (lvl_q[0]) begin
                    hold_d = '0;
                end else if (hold_q == HoldLast) begin
                    state_d   = RUN;
                    hold_d    = '0;
                    soc_rst_d = 1'b1;
                    boot_d    = boot_s2_q;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (rst_rise) begin
                    state_d   = HOLD;
                    hold_d    = '0;
                    soc_rst_d = 1'b0;
                end
            end
        endcase
    end

    // A write landing on the wrap cycle bypasses pending straight into active.
    always_comb begin
        wrap   = (pcnt_q == CntLast);
        pcnt_d = wrap ? '0 : pcnt_q + 1'b1;
        pend_d = duty_bus.fan_duty_we_i ? duty_bus.fan_duty_i : pend_q;
        act_d  = wrap ? pend_d : act_q;
        pwm_d  = (pcnt_q < act_q);
        sw_d   = (act_q != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            boot_s1_q <= '0;
            boot_s2_q <= '0;
            lvl_q     <= '0;
            for (int i = 0; i < NumDb; i++) db_cnt_q[i] <= '0;
            pulse_q   <= '0;
            state_q   <= HOLD;
            hold_q    <= '0;
            soc_rst_q <= 1'b0;
            boot_q    <= '0;
            pcnt_q    <= '0;
            pend_q    <= DutyRst;
            act_q     <= DutyRst;
            pwm_q     <= 1'b0;
            sw_q      <= 1'b0;
        end else begin
            sync1_q   <= {btn_i, cpu_reset_i};
            sync2_q   <= sync1_q;
            boot_s1_q <= boot_mode_i;
            boot_s2_q <= boot_s1_q;
            lvl_q     <= lvl_d;
            for (int i = 0; i < NumDb; i++) db_cnt_q[i] <= db_cnt_d[i];
            pulse_q   <= pulse_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            soc_rst_q <= soc_rst_d;
            boot_q    <= boot_d;
            pcnt_q    <= pcnt_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            pwm_q     <= pwm_d;
            sw_q      <= sw_d;
        end
    end

    assign soc_rst_no  = soc_rst_q;
    assign boot_mode_o = boot_q;
    assign btn_o       = lvl_q[NumDb-1:1];
    assign btn_pulse_o = pulse_q;
    assign fan_pwm_o   = pwm_q;
    assign fan_sw_o    = sw_q;
endmodule

// File: tb/tb_cheshire_board_ctrl.sv
// Directed bench for cheshire_board_ctrl: stimulus queues expected values,
// a negedge monitor pops and compares them against the outputs.
module tb_cheshire_board_ctrl;
    localparam int Per = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_reset;
    logic [3:0] btn;
    logic [1:0] boot;
    logic       soc_rst_no;
    logic [1:0] boot_mode_o;
    logic [3:0] btn_o;
    logic [3:0] btn_pulse_o;
    logic       fan_pwm_o;
    logic       fan_sw_o;

    cheshire_board_ctrl_if #(.PwmWidth(4)) bus ();

    cheshire_board_ctrl #(
        .NumButtons     (4),
        .DebounceCycles (4),
        .ResetHoldCycles(8),
        .BootModeWidth  (2),
        .PwmWidth       (4),
        .FanDutyDefault (15)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_reset_i (cpu_reset),
        .btn_i       (btn),
        .boot_mode_i (boot),
        .duty_bus    (bus.slave),
        .soc_rst_no  (soc_rst_no),
        .boot_mode_o (boot_mode_o),
        .btn_o       (btn_o),
        .btn_pulse_o (btn_pulse_o),
        .fan_pwm_o   (fan_pwm_o),
        .fan_sw_o    (fan_sw_o)
    );

    always #5 clk = ~clk;

    localparam int S_SOC = 0, S_BOOT = 1, S_BTN = 2;
    localparam int S_PUL = 3, S_PWM = 4, S_SW = 5;

    typedef struct {
        int         sel;
        logic [7:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    function automatic logic [7:0] act(int sel);
        case (sel)
            S_SOC:   return 8'(soc_rst_no);
            S_BOOT:  return 8'(boot_mode_o);
            S_BTN:   return 8'(btn_o);
            S_PUL:   return 8'(btn_pulse_o);
            S_PWM:   return 8'(fan_pwm_o);
            default: return 8'(fan_sw_o);
        endcase
    endfunction

    exp_t       cur;
    logic [7:0] got;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            got = act(cur.sel);
            checks++;
            if (got !== cur.v) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h at %0t",
                         cur.nm, got, cur.v, $time);
            end
        end
    end

    task automatic expv(int sel, int v, string nm);
        exp_t e;
        e.sel = sel;
        e.v   = v[7:0];
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_reset_vals(string tag);
        expv(S_SOC,  0, {tag, "_soc"});
        expv(S_BOOT, 0, {tag, "_boot"});
        expv(S_BTN,  0, {tag, "_btn"});
        expv(S_PUL,  0, {tag, "_pulse"});
        expv(S_PWM,  0, {tag, "_pwm"});
        expv(S_SW,   0, {tag, "_sw"});
    endtask

    // Position so the next edge is the PWM wrap edge, then write on it.
    task automatic write_at_wrap(int d);
        while (((cyc + 1) % Per) != 0) tick(1);
        bus.fan_duty_i    = 4'(d);
        bus.fan_duty_we_i = 1'b1;
        tick(1);
        bus.fan_duty_we_i = 1'b0;
    endtask

    task automatic pwm_period(int d);
        write_at_wrap(d);
        for (int j = 1; j <= Per; j++) begin
            tick(1);
            expv(S_PWM, ((j - 1) < d) ? 1 : 0, $sformatf("pwm_d%0d_%0d", d, j));
            expv(S_SW, (d != 0) ? 1 : 0, $sformatf("sw_d%0d", d));
        end
    endtask

    initial begin
        rst               = 1'b1;
        cpu_reset         = 1'b0;
        btn               = '0;
        boot              = 2'b10;
        bus.fan_duty_i    = '0;
        bus.fan_duty_we_i = 1'b0;

        tick(2);
        exp_reset_vals("por");
        tick(1);
        rst = 1'b0;

        for (int e = 1; e <= 8; e++) begin
            tick(1);
            expv(S_SOC, (e >= 8) ? 1 : 0, $sformatf("pwrup_soc_e%0d", e));
        end
        expv(S_BOOT, 2, "pwrup_boot");
        boot = 2'b01;
        tick(5);
        expv(S_BOOT, 2, "boot_held");

        btn[0] = 1'b1;
        tick(3);
        btn[0] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            expv(S_BTN, 0, "glitch_btn");
            expv(S_PUL, 0, "glitch_pulse");
        end

        btn[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            if (e == 10) btn[0] = 1'b0;
            expv(S_BTN, (e >= 6) ? 1 : 0, $sformatf("btn_e%0d", e));
            expv(S_PUL, (e == 6) ? 1 : 0, $sformatf("pulse_e%0d", e));
        end
        tick(10);
        expv(S_BTN, 0, "btn_release");

        boot      = 2'b11;
        cpu_reset = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick(1);
            if (e == 20) cpu_reset = 1'b0;
            expv(S_SOC, (e < 6 || e >= 34) ? 1 : 0, $sformatf("btnrst_soc_e%0d", e));
            if (e == 33) expv(S_BOOT, 2, "btnrst_boot_old");
            if (e == 34) expv(S_BOOT, 3, "btnrst_boot_new");
        end

        pwm_period(5);
        pwm_period(0);
        pwm_period(15);

        write_at_wrap(10);
        for (int j = 1; j <= 2 * Per; j++) begin
            tick(1);
            if (j == 7) begin
                bus.fan_duty_i    = 4'd3;
                bus.fan_duty_we_i = 1'b1;
            end
            if (j == 8) bus.fan_duty_we_i = 1'b0;
            if (j <= Per)
                expv(S_PWM, ((j - 1) < 10) ? 1 : 0, $sformatf("upd_old_%0d", j));
            else
                expv(S_PWM, ((j - 16) < 3) ? 1 : 0, $sformatf("upd_new_%0d", j));
        end

        write_at_wrap(5);
        tick(4);
        expv(S_SOC, 1, "pre_rst_soc");
        expv(S_SW,  1, "pre_rst_sw");
        tick(1);
        rst = 1'b1;
        exp_reset_vals("midrst");
        tick(2);
        rst = 1'b0;
        for (int e = 1; e <= Per; e++) begin
            tick(1);
            expv(S_SOC, (e >= 8) ? 1 : 0, $sformatf("rerun_soc_e%0d", e));
            expv(S_BOOT, (e >= 8) ? 3 : 0, $sformatf("rerun_boot_e%0d", e));
            expv(S_PWM, 1, $sformatf("rerun_pwm_e%0d", e));
            expv(S_SW, 1, "rerun_sw");
        end

        repeat (4) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
